// File: rtl/change_trace_monitor_pkg.sv
// trace_pkg: shared defaults, trace entry layout and saturating counter helper.
package trace_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int TS_W_DEF   = 16;
  localparam int DEPTH_DEF  = 8;
  typedef struct packed {
    logic [TS_W_DEF-1:0]   ts;
    logic [DATA_W_DEF-1:0] data;
  } trace_entry_t;
  // Increments v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max;
    max = (32'd1 << w) - 32'd1;
    return (v >= max) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/change_trace_monitor_fifo.sv
// sync_fifo: single-clock FIFO of trace entries with wrap-bit pointers.
module sync_fifo
  import trace_pkg::*;
#(
  parameter int WIDTH = $bits(trace_entry_t),
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr, r_rd;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop) r_rd <= r_rd + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_wdata;
  end
  assign o_rdata = r_mem[r_rd[AW-1:0]];
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_level = r_wr - r_rd;
endmodule

// File: rtl/change_trace_monitor.sv
// change_trace_monitor: records {timestamp, value} on every change of a watched bus.
module change_trace_monitor
  import trace_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic                     clear_i,
  input  logic [DATA_W-1:0]        data_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [TS_W-1:0]          out_ts_o,
  output logic                     out_bit0_o,
  output logic                     overflow_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int EW = TS_W + DATA_W;
  logic [TS_W-1:0]   r_ts;
  logic [DATA_W-1:0] r_prev;
  logic              r_first, r_ovf;
  logic [DROP_W-1:0] r_drop;
  logic              w_evt, w_full, w_empty, w_pop, w_push, w_drop;
  logic [EW-1:0]     w_head;
  assign w_evt  = en_i & (r_first | (data_i != r_prev));
  assign w_pop  = ~w_empty & out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = w_evt & (~w_full | w_pop);
  assign w_drop = w_evt & w_full & ~w_pop;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts    <= '0;
      r_prev  <= '0;
      r_first <= 1'b1;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else begin
      r_ts    <= r_ts + 1'b1;
      if (w_evt) r_prev <= data_i;
      r_first <= clear_i | (r_first & ~w_evt);
      r_ovf   <= ~clear_i & (r_ovf | w_drop);
      r_drop  <= clear_i ? '0 : w_drop ? DROP_W'(sat_inc(32'(r_drop), DROP_W)) : r_drop;
    end
  end
  sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({r_ts, data_i}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level_o)
  );
  assign out_valid_o = ~w_empty;
  assign out_ts_o    = w_empty ? '0 : w_head[EW-1:DATA_W];
  assign out_data_o  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign out_bit0_o  = out_data_o[0];
  assign overflow_o  = r_ovf;
  assign drop_cnt_o  = r_drop;
endmodule

// File: tb/tb_change_trace_monitor.sv
// tb_change_trace_monitor: vector table plus queue scoreboard for the change trace monitor.
module tb_change_trace_monitor;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en_i = 1'b0, clear_i = 1'b0, out_ready_i = 1'b0;
  logic [3:0]  data_i = '0;
  logic        out_valid_o, out_bit0_o, overflow_o;
  logic [3:0]  out_data_o;
  logic [15:0] out_ts_o;
  logic [7:0]  drop_cnt_o;
  logic [3:0]  level_o;
  logic        w_en = 1'b0, w_ready = 1'b0;
  logic [3:0]  w_data = '0;
  logic        w_valid, w_bit0, w_ovf;
  logic [3:0]  w_out_data, w_out_ts, w_level;
  logic [7:0]  w_drop;

  change_trace_monitor dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i), .data_i(data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_ts_o(out_ts_o), .out_bit0_o(out_bit0_o), .overflow_o(overflow_o),
    .drop_cnt_o(drop_cnt_o), .level_o(level_o));

  change_trace_monitor #(.TS_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .en_i(w_en), .clear_i(1'b0), .data_i(w_data),
    .out_valid_o(w_valid), .out_ready_i(w_ready), .out_data_o(w_out_data),
    .out_ts_o(w_out_ts), .out_bit0_o(w_bit0), .overflow_o(w_ovf),
    .drop_cnt_o(w_drop), .level_o(w_level));

  always #5 clk = ~clk;

  typedef struct { logic en, clr; logic [3:0] d; logic rdy; int lvl, drop; logic ovf; } vec_t;
  typedef struct { logic [15:0] ts; logic [3:0] d; } ent_t;
  vec_t vecs[$];
  ent_t sb[$];
  int npass = 0, ntot = 0;
  logic [15:0] m_ts = '0;
  logic [3:0]  m_prev = '0;
  logic        m_first = 1'b1, m_ovf = 1'b0;
  int          m_drop = 0;

  function automatic vec_t mk(logic en, logic clr, logic [3:0] d, logic rdy, int lvl, int drop, logic ovf);
    vec_t v;
    v.en = en; v.clr = clr; v.d = d; v.rdy = rdy; v.lvl = lvl; v.drop = drop; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string n, input longint act, input longint exp);
    ntot++;
    if (act != exp) $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
    else npass++;
  endtask

  task automatic check_state();
    chk("level", level_o, sb.size());
    chk("valid", out_valid_o, sb.size() != 0);
    chk("drop_cnt", drop_cnt_o, m_drop);
    chk("overflow", overflow_o, m_ovf);
    if (sb.size() != 0) begin
      chk("head_data", out_data_o, sb[0].d);
      chk("head_ts", out_ts_o, sb[0].ts);
      chk("head_bit0", out_bit0_o, sb[0].d[0]);
    end else begin
      chk("empty_data", out_data_o, 0);
      chk("empty_ts", out_ts_o, 0);
    end
  endtask

  // One clock: drive inputs, advance the reference model, then compare after the edge.
  task automatic cyc(input logic en, input logic clr, input logic [3:0] d, input logic rdy);
    ent_t e;
    bit full, pop, evt;
    en_i = en; clear_i = clr; data_i = d; out_ready_i = rdy;
    full = sb.size() == 8;
    pop  = rdy && sb.size() != 0;
    evt  = en && (m_first || d != m_prev);
    if (pop) void'(sb.pop_front());
    if (evt) begin
      if (!full || pop) begin
        e.ts = m_ts; e.d = d;
        sb.push_back(e);
      end else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
      m_prev = d; m_first = 1'b0;
    end
    if (clr) begin m_first = 1'b1; m_ovf = 1'b0; m_drop = 0; end
    m_ts++;
    @(posedge clk); #1;
    check_state();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back(mk(1, 0, 4'h0, 1, 1, 0, 0));
    for (int i = 1; i < 5; i++) vecs.push_back(mk(1, 0, 4'h0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'hB, 1, 1, 0, 0));
    for (int i = 6; i < 9; i++) vecs.push_back(mk(1, 0, 4'hB, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 4'h2, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 4'h2, 1, 0, 0, 0));
    for (int i = 0; i < 11; i++)
      vecs.push_back(mk(1, 0, (i % 2 == 0) ? 4'h5 : 4'hA, 0, (i < 8) ? i + 1 : 8, (i < 8) ? 0 : i - 7, i >= 8));
    vecs.push_back(mk(1, 0, 4'hA, 1, 8, 3, 1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 0, 4'hA, 1, 7 - i, 3, 1));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_level", level_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_ts", out_ts_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].clr, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d_level", i), level_o, vecs[i].lvl);
      chk($sformatf("vec%0d_drop", i), drop_cnt_o, vecs[i].drop);
      chk($sformatf("vec%0d_ovf", i), overflow_o, vecs[i].ovf);
    end

    cyc(1, 0, 4'h3, 1);
    cyc(1, 0, 4'h3, 1);
    cyc(0, 0, 4'h7, 1);
    cyc(0, 0, 4'h7, 1);
    chk("disabled_no_entry", level_o, 0);
    cyc(1, 0, 4'h7, 1);
    chk("reenable_entry", level_o, 1);
    cyc(1, 0, 4'h7, 1);
    cyc(1, 1, 4'h7, 1);
    chk("clear_ovf", overflow_o, 0);
    chk("clear_drop", drop_cnt_o, 0);
    cyc(1, 0, 4'h7, 1);
    chk("forced_entry", level_o, 1);
    cyc(1, 0, 4'h7, 1);

    for (int i = 0; i < 8; i++) cyc(1, 0, (i % 2 == 0) ? 4'hC : 4'h3, 0);
    chk("refill_level", level_o, 8);
    cyc(1, 1, 4'hC, 0);
    chk("clear_wins_drop", drop_cnt_o, 0);
    chk("clear_wins_ovf", overflow_o, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 4'hC, 1);

    for (int i = 0; i < 9; i++) cyc(1, 0, (i % 2 == 0) ? 4'h5 : 4'hA, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'hA, 1);
    chk("pre_reset_level", level_o, 5);
    chk("pre_reset_ovf", overflow_o, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid_o, 0);
    chk("midrst_level", level_o, 0);
    chk("midrst_data", out_data_o, 0);
    chk("midrst_ts", out_ts_o, 0);
    chk("midrst_ovf", overflow_o, 0);
    chk("midrst_drop", drop_cnt_o, 0);
    sb.delete();
    m_ts = '0; m_prev = '0; m_first = 1'b1; m_ovf = 1'b0; m_drop = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int k = 0; k < 20; k++) begin
      w_en = 1'b1; w_ready = 1'b1; w_data = (k % 2 == 1) ? 4'h5 : 4'hA;
      cyc(0, 0, 4'h0, 0);
      chk($sformatf("wrap%0d_valid", k), w_valid, 1);
      chk($sformatf("wrap%0d_ts", k), w_out_ts, k % 16);
      chk($sformatf("wrap%0d_data", k), w_out_data, (k % 2 == 1) ? 5 : 10);
      chk($sformatf("wrap%0d_level", k), w_level, 1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
